uart_rx_stop_check: RTL and testbench

Parametrised stop-bit checker for the UART receiver. After the data and parity bits, the receiver front end asserts a start pulse. The checker then takes a 3-sample majority vote at mid-bit on each of 1 or 2 stop bits. It reports a per-frame verdict (ok / framing error / break) and keeps a sticky framing-error flag and a saturating error counter for status readback.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_mid_bit_voter.sv | 56 +++++
 rtl/uart_rx_stop_check.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_stop_check.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART receiver: checker state encoding,
//           legal configuration ranges and the mid-bit sample position helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RESULT = 2'd2
  } uart_state_e;

  localparam int c_OVERSAMPLE_MIN = 4;
  localparam int c_STOP_BITS_MIN  = 1;
  localparam int c_STOP_BITS_MAX  = 2;

  // Tick index of sample 'offs' (0..2) of bit 'bit_idx'. The three samples
  // straddle the bit centre: centre-1, centre, centre+1.
  function automatic int mid_sample_k(input int bit_idx, input int os, input int offs);
    return bit_idx * os + os / 2 - 1 + offs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mid_bit_voter.sv
`default_nettype none
// ============================================================================
// Module  : uart_mid_bit_voter
// Purpose : Accumulates three mid-bit samples per bit and presents a 2-of-3
//           majority vote for each bit.
// Ports   : Clk, reset      - clock, asynchronous active-high reset
//           clear_in        - zero all accumulators (start of a new check)
//           tick_in         - sample tick, already qualified by the caller
//           k_in            - tick index within the checked window
//           rx_in           - synchronised serial line
//           vote_out        - per-bit majority vote (1 = at least two ones)
// Revision: 1.0 - initial release
// ============================================================================
module uart_mid_bit_voter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int NUM_BITS   = 2,
  parameter int K_W        = 5
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                clear_in,
  input  logic                tick_in,
  input  logic [K_W-1:0]      k_in,
  input  logic                rx_in,
  output logic [NUM_BITS-1:0] vote_out
);

  for (genvar b = 0; b < NUM_BITS; b++) begin : g_bit
    localparam int c_K_FIRST = mid_sample_k(b, OVERSAMPLE, 0);
    localparam logic [K_W-1:0] c_K_LO = K_W'(c_K_FIRST);
    localparam logic [K_W-1:0] c_K_HI = K_W'(c_K_FIRST + 2);

    logic       w_hit;
    logic [1:0] r_ones;

    assign w_hit = tick_in && (k_in >= c_K_LO) && (k_in <= c_K_HI);

    // Counting ones is enough: with three samples, bit 1 of the count is
    // exactly the "two or more" majority.
    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        r_ones <= 2'd0;
      end else if (clear_in) begin
        r_ones <= 2'd0;
      end else if (w_hit && rx_in) begin
        r_ones <= r_ones + 2'd1;
      end
    end

    assign vote_out[b] = r_ones[1];
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_stop_check.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_stop_check
// Purpose : Stop-bit checker. Votes each of STOP_BITS stop bits at mid-bit,
//           reports ok / framing error / break per frame and keeps a sticky
//           framing-error flag plus a saturating error counter.
// Ports   : Clk, reset              - clock, asynchronous active-high reset
//           sample_tick_in          - oversample tick
//           rx_in                   - synchronised serial line
//           check_start_in          - start of first stop-bit period
//           data_zero_in            - all data bits were 0 (start cycle only)
//           err_clear_in            - clear sticky flag and counter
//           busy_out                - check in progress
//           done_out                - verdict valid this cycle
//           frame_ok_out            - all stop bits voted 1
//           framing_err_out         - some stop bit voted 0
//           break_out               - data all 0 and all stop bits voted 0
//           framing_err_sticky_out  - sticky framing-error flag
//           err_count_out           - saturating framing-error count
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_stop_check
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 sample_tick_in,
  input  logic                 rx_in,
  input  logic                 check_start_in,
  input  logic                 data_zero_in,
  input  logic                 err_clear_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 frame_ok_out,
  output logic                 framing_err_out,
  output logic                 break_out,
  output logic                 framing_err_sticky_out,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  localparam int c_K_W = $clog2(STOP_BITS * OVERSAMPLE);
  // The check ends on the last sample of the last stop bit, i.e. at its
  // middle, so the receiver can start hunting for the next start edge.
  localparam logic [c_K_W-1:0]     c_K_LAST  = c_K_W'(mid_sample_k(STOP_BITS - 1, OVERSAMPLE, 2));
  localparam logic [ERR_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] c_CNT_ONE = ERR_CNT_W'(1);

  if ((OVERSAMPLE < c_OVERSAMPLE_MIN) || ((OVERSAMPLE % 2) != 0) ||
      (STOP_BITS < c_STOP_BITS_MIN) || (STOP_BITS > c_STOP_BITS_MAX)) begin : g_bad_cfg
    $error("uart_rx_stop_check: illegal OVERSAMPLE/STOP_BITS configuration");
  end

  uart_state_e          r_state, w_state_nxt;
  logic [c_K_W-1:0]     r_k, w_k_nxt;
  logic                 r_data_zero, w_data_zero_nxt;
  logic                 w_clear_votes;
  logic                 w_tick_sample;
  logic [STOP_BITS-1:0] w_vote;
  logic                 r_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  uart_mid_bit_voter #(
    .OVERSAMPLE (OVERSAMPLE),
    .NUM_BITS   (STOP_BITS),
    .K_W        (c_K_W)
  ) u_voter (
    .Clk      (Clk),
    .reset    (reset),
    .clear_in (w_clear_votes),
    .tick_in  (w_tick_sample),
    .k_in     (r_k),
    .rx_in    (rx_in),
    .vote_out (w_vote)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_data_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_data_zero <= w_data_zero_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_data_zero_nxt = r_data_zero;
    w_clear_votes   = 1'b0;
    w_tick_sample   = 1'b0;
    busy_out        = (r_state != ST_IDLE);
    done_out        = 1'b0;
    frame_ok_out    = 1'b0;
    framing_err_out = 1'b0;
    break_out       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A tick coinciding with the start is deliberately not counted.
        if (check_start_in) begin
          w_state_nxt     = ST_SAMPLE;
          w_k_nxt         = '0;
          w_data_zero_nxt = data_zero_in;
          w_clear_votes   = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (sample_tick_in) begin
          w_tick_sample = 1'b1;
          if (r_k == c_K_LAST) begin
            w_state_nxt = ST_RESULT;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end
      end
      ST_RESULT: begin
        w_state_nxt     = ST_IDLE;
        done_out        = 1'b1;
        frame_ok_out    = &w_vote;
        framing_err_out = ~(&w_vote);
        break_out       = r_data_zero & ~(|w_vote);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status registers follow the RESULT verdict by one cycle. A new error
  // wins over a simultaneous clear, so a clear never hides that error.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_sticky    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (framing_err_out) begin
        r_sticky <= 1'b1;
      end else if (err_clear_in) begin
        r_sticky <= 1'b0;
      end

      if (err_clear_in) begin
        r_err_count <= framing_err_out ? c_CNT_ONE : '0;
      end else if (framing_err_out && (r_err_count != c_CNT_MAX)) begin
        r_err_count <= r_err_count + c_CNT_ONE;
      end
    end
  end

  assign framing_err_sticky_out = r_sticky;
  assign err_count_out          = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stop_check.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_stop_check
// Purpose : Self-checking bench for uart_rx_stop_check (OVERSAMPLE=16,
//           STOP_BITS=2, ERR_CNT_W=2). Frames are described by the rx value
//           seen on each tick index; the expected verdict is queued and a
//           monitor compares it whenever done_out fires.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_stop_check;

  localparam int OS     = 16;
  localparam int SB     = 2;
  localparam int CW     = 2;
  localparam int K_LAST = (SB - 1) * OS + OS / 2 + 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick_in = 1'b0;
  logic          rx_in = 1'b1;
  logic          check_start_in = 1'b0;
  logic          data_zero_in = 1'b0;
  logic          err_clear_in = 1'b0;
  logic          busy_out, done_out, frame_ok_out, framing_err_out, break_out;
  logic          framing_err_sticky_out;
  logic [CW-1:0] err_count_out;

  uart_rx_stop_check #(
    .OVERSAMPLE (OS),
    .STOP_BITS  (SB),
    .ERR_CNT_W  (CW)
  ) dut (
    .Clk                    (Clk),
    .reset                  (reset),
    .sample_tick_in         (sample_tick_in),
    .rx_in                  (rx_in),
    .check_start_in         (check_start_in),
    .data_zero_in           (data_zero_in),
    .err_clear_in           (err_clear_in),
    .busy_out               (busy_out),
    .done_out               (done_out),
    .frame_ok_out           (frame_ok_out),
    .framing_err_out        (framing_err_out),
    .break_out              (break_out),
    .framing_err_sticky_out (framing_err_sticky_out),
    .err_count_out          (err_count_out)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic ok;
    logic ferr;
    logic brk;
  } verdict_t;

  verdict_t exp_q[$];
  verdict_t mon_v;
  int       n_tests = 0;
  int       n_fail  = 0;
  int       n_done  = 0;
  int       exp_cnt = 0;
  bit       exp_sticky = 1'b0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference verdict: majority of the three samples around each stop-bit
  // centre, then the frame-level rules.
  function automatic verdict_t model(input logic [31:0] pat, input bit dz);
    verdict_t v;
    int       zero_bits = 0;
    for (int b = 0; b < SB; b++) begin
      int c = b * OS + OS / 2;
      int ones = int'(pat[c - 1]) + int'(pat[c]) + int'(pat[c + 1]);
      if (ones < 2) zero_bits++;
    end
    v.ok   = (zero_bits == 0);
    v.ferr = (zero_bits > 0);
    v.brk  = dz && (zero_bits == SB);
    return v;
  endfunction

  task automatic model_status(input bit err, input bit clr);
    if (clr && err)      exp_cnt = 1;
    else if (clr)        exp_cnt = 0;
    else if (err && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    if (err)             exp_sticky = 1'b1;
    else if (clr)        exp_sticky = 1'b0;
  endtask

  // Monitor: every done_out must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (!reset && done_out) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got done_out=1 expected no pending frame");
      end else begin
        mon_v = exp_q.pop_front();
        check1("frame_ok", frame_ok_out, mon_v.ok);
        check1("framing_err", framing_err_out, mon_v.ferr);
        check1("break", break_out, mon_v.brk);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick_in = 1'($urandom_range(0, 1));
      rx_in          = 1'($urandom);
      @(posedge Clk); #1;
    end
    sample_tick_in = 1'b0;
  endtask

  task automatic clear_alone();
    err_clear_in = 1'b1;
    @(posedge Clk); #1;
    err_clear_in = 1'b0;
    model_status(1'b0, 1'b1);
    @(negedge Clk);
    check1("clear_count", err_count_out, exp_cnt);
    check1("clear_sticky", framing_err_sticky_out, exp_sticky);
    @(posedge Clk); #1;
  endtask

  // Run one frame. pat[k] is rx_in on tick k. abort_k >= 0 applies reset
  // instead of tick abort_k. dbl pulses check_start_in again mid-frame.
  task automatic run_frame(input logic [31:0] pat, input bit dz, input bit clr,
                           input int abort_k, input bit dbl);
    verdict_t v;
    v = model(pat, dz);
    check_start_in = 1'b1;
    data_zero_in   = dz;
    sample_tick_in = 1'($urandom_range(0, 1));
    rx_in          = 1'($urandom);
    if (abort_k < 0) exp_q.push_back(v);
    @(posedge Clk); #1;
    check_start_in = 1'b0;
    data_zero_in   = 1'($urandom);
    check1("busy_after_start", busy_out, 1);
    for (int k = 0; k <= K_LAST; k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        sample_tick_in = 1'b0;
        rx_in          = 1'($urandom);
        @(posedge Clk); #1;
      end
      if (k == abort_k) begin
        sample_tick_in = 1'b0;
        reset          = 1'b1;
        @(negedge Clk);
        check1("reset_abort_outputs",
               {busy_out, done_out, frame_ok_out, framing_err_out, break_out,
                framing_err_sticky_out, err_count_out}, 0);
        @(posedge Clk); #1;
        reset      = 1'b0;
        exp_cnt    = 0;
        exp_sticky = 1'b0;
        idle(OS * SB);
        check1("no_busy_after_abort", busy_out, 0);
        return;
      end
      sample_tick_in = 1'b1;
      rx_in          = pat[k];
      check_start_in = dbl && (k == 5);
      @(posedge Clk); #1;
      check_start_in = 1'b0;
    end
    sample_tick_in = 1'b0;
    rx_in          = 1'($urandom);
    err_clear_in   = clr;
    @(negedge Clk);
    check1("done_timing", done_out, 1);
    @(posedge Clk); #1;
    err_clear_in = 1'b0;
    model_status(v.ferr, clr);
    @(negedge Clk);
    check1("sticky", framing_err_sticky_out, exp_sticky);
    check1("err_count", err_count_out, exp_cnt);
    check1("busy_after_result", busy_out, 0);
    @(posedge Clk); #1;
  endtask

  function automatic logic [31:0] rand_pat();
    logic [31:0] p;
    p = $urandom;
    for (int b = 0; b < SB; b++) begin
      int c = b * OS + OS / 2;
      case ($urandom_range(0, 3))
        0: begin p[c - 1] = 1'b1; p[c] = 1'b1; p[c + 1] = 1'b1; end
        1: begin p[c - 1] = 1'b0; p[c] = 1'b0; p[c + 1] = 1'b0; end
        default: ;
      endcase
    end
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int          d0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check1("reset_outputs",
           {busy_out, done_out, frame_ok_out, framing_err_out, break_out,
            framing_err_sticky_out, err_count_out}, 0);
    @(posedge Clk); #1;
    reset = 1'b0;
    idle(10);
    check1("idle_ticks_no_busy", busy_out, 0);

    // All stop bits high.
    run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0);
    // Second stop bit low.
    run_frame(32'h0000_FFFF, 1'b0, 1'b0, -1, 1'b0);
    clear_alone();
    // Single-sample glitch at the centre of bit 0.
    p = 32'hFFFF_FFFF;
    p[8] = 1'b0;
    run_frame(p, 1'b0, 1'b0, -1, 1'b0);
    // Break: data all zero and line low for the whole frame.
    run_frame(32'h0, 1'b1, 1'b0, -1, 1'b0);
    // Saturation.
    for (int i = 0; i < 5; i++) run_frame(32'h0000_FFFF, 1'b0, 1'b0, -1, 1'b0);
    check1("count_saturated", err_count_out, CNT_MAX);
    // Clear together with an error.
    run_frame(32'hFFFF_0000, 1'b0, 1'b1, -1, 1'b0);
    check1("clear_with_error_count", err_count_out, 1);
    // Reset at k=12.
    run_frame(32'h0, 1'b0, 1'b0, 12, 1'b0);
    // Second start while busy is ignored.
    d0 = n_done;
    run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b1);
    idle(OS * SB);
    check1("single_done_on_double_start", n_done - d0, 1);

    for (int i = 0; i < 40; i++) begin
      run_frame(rand_pat(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), -1, 1'b0);
      idle($urandom_range(0, 4));
    end

    idle(5);
    check1("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
